sample_pacer: RTL and testbench

SAMPLE_PACER -- requirements
Module: sample_pacer

---
 rtl/sample_pacer.sv | 100 ++++++++++
 tb/tb_sample_pacer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_pacer.sv
// Sample pacer: a small FIFO drained at one sample every PERIOD enabled clocks,
// with a strobe per output slot and a sticky underflow flag for empty slots.
module sample_pacer #(
    parameter int WIDTH  = 16,
    parameter int PERIOD = 128,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     enable_in,
    input  logic                     wr_valid_in,
    input  logic [WIDTH-1:0]         wr_data_in,
    output logic                     wr_ready_out,
    output logic                     ready_out,
    output logic [WIDTH-1:0]         signal_out,
    output logic                     underflow_out,
    input  logic                     clear_in,
    output logic [$clog2(DEPTH):0]   level_out
);

    localparam int CW = $clog2(PERIOD);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CW-1:0]    cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             tick;
    logic             push;
    logic             pop;
    logic             empty;

    // Full/empty decisions use the level before this edge, so a tick never
    // frees room for a same-edge push and a same-edge push never feeds a pop.
    assign empty        = (level_out == '0);
    assign wr_ready_out = (level_out != LW'(DEPTH));
    assign tick         = enable_in && (cnt == CW'(PERIOD - 1));
    assign push         = wr_valid_in && wr_ready_out;
    assign pop          = tick && !empty;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            cnt <= '0;
        end else if (!enable_in || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers and level define contents.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_out <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_out <= level_out + 1'b1;
                2'b01:   level_out <= level_out - 1'b1;
                default: level_out <= level_out;
            endcase
        end
    end

    // An empty slot still strobes with zero so the downstream rate never slips.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ready_out     <= 1'b0;
            signal_out    <= '0;
            underflow_out <= 1'b0;
        end else begin
            ready_out <= tick;
            if (pop) begin
                signal_out <= mem[rd_ptr];
            end else if (tick) begin
                signal_out <= '0;
            end
            if (tick && empty) begin
                underflow_out <= 1'b1;
            end else if (clear_in) begin
                underflow_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed strobe timing and values.
module tb_sample_pacer;

    localparam int WIDTH  = 16;
    localparam int PERIOD = 128;
    localparam int DEPTH  = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             clear = 1'b0;
    logic             wr_ready;
    logic             ready;
    logic [WIDTH-1:0] signal;
    logic             underflow;
    logic [LW-1:0]    level;

    int errors = 0;
    int checks = 0;

    sample_pacer #(.WIDTH(WIDTH), .PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
        .clk_in        (clk),
        .reset_in      (rst_n),
        .enable_in     (enable),
        .wr_valid_in   (wr_valid),
        .wr_data_in    (wr_data),
        .wr_ready_out  (wr_ready),
        .ready_out     (ready),
        .signal_out    (signal),
        .underflow_out (underflow),
        .clear_in      (clear),
        .level_out     (level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of samples and a count of consecutive enabled edges.
    logic [WIDTH-1:0] q[$];
    int               run_len = 0;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_sig = '0;
    logic             m_uf = 1'b0;
    logic             m_tick;
    logic             m_was_empty;
    logic             m_was_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            run_len = 0;
            m_ready = 1'b0;
            m_sig   = '0;
            m_uf    = 1'b0;
        end else begin
            m_was_empty = (q.size() == 0);
            m_was_full  = (q.size() == DEPTH);
            m_tick      = 1'b0;
            if (enable) begin
                run_len = run_len + 1;
                if (run_len == PERIOD) begin
                    m_tick  = 1'b1;
                    run_len = 0;
                end
            end else begin
                run_len = 0;
            end
            m_ready = m_tick;
            if (m_tick) begin
                m_sig = m_was_empty ? '0 : q.pop_front();
            end
            if (m_tick && m_was_empty) m_uf = 1'b1;
            else if (clear) m_uf = 1'b0;
            if (wr_valid && !m_was_full) q.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc_ready", ready, m_ready);
        checkOutput("cyc_signal", signal, m_sig);
        checkOutput("cyc_underflow", underflow, m_uf);
        checkOutput("cyc_level", level, q.size());
        checkOutput("cyc_wr_ready", wr_ready, (q.size() != DEPTH));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic valid,
                                 input logic [WIDTH-1:0] data, input logic clr);
        enable   = en;
        wr_valid = valid;
        wr_data  = data;
        clear    = clr;
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (n < 2 * PERIOD) begin
            step(1);
            n++;
            if (ready) return;
        end
        checkOutput("strobe_timeout", n, PERIOD);
    endtask

    int n;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        step(1);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_wr_ready", wr_ready, 1);
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_signal", signal, 0);
        checkOutput("reset_underflow", underflow, 0);
        rst_n = 1'b1;

        $display("[TB] three samples paced out");
        applyStimulus(1'b0, 1'b1, 16'd5, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b1, 16'(-3), 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b1, 16'd7, 1'b0);
        step(1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("s1_level", level, 3);
        wait_strobe(n);
        checkOutput("s1_gap0", n, 128);
        checkOutput("s1_val0", $signed(signal), 5);
        wait_strobe(n);
        checkOutput("s1_gap1", n, 128);
        checkOutput("s1_val1", $signed(signal), -3);
        wait_strobe(n);
        checkOutput("s1_gap2", n, 128);
        checkOutput("s1_val2", $signed(signal), 7);
        checkOutput("s1_underflow", underflow, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        step(3);

        $display("[TB] underflow and clear");
        do_reset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        wait_strobe(n);
        checkOutput("s2_gap", n, 128);
        checkOutput("s2_val", signal, 0);
        checkOutput("s2_underflow_set", underflow, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        step(5);
        checkOutput("s2_underflow_held", underflow, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("s2_underflow_clr", underflow, 0);

        $display("[TB] fill to full, refused until first tick");
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(100 + i), 1'b0);
            step(1);
        end
        checkOutput("s3_level_full", level, 16);
        checkOutput("s3_wr_ready_full", wr_ready, 0);
        applyStimulus(1'b1, 1'b1, 16'd116, 1'b0);
        wait_strobe(n);
        checkOutput("s3_gap", n, 128);
        checkOutput("s3_val", signal, 100);
        checkOutput("s3_level_after_tick", level, 15);
        step(1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("s3_level_refill", level, 16);
        wait_strobe(n);
        checkOutput("s3_val1", signal, 101);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        step(2);

        $display("[TB] push on the tick edge");
        do_reset();
        applyStimulus(1'b0, 1'b1, 16'd11, 1'b0);
        step(1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        step(PERIOD - 1);
        applyStimulus(1'b1, 1'b1, 16'd22, 1'b0);
        step(1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("s4_ready", ready, 1);
        checkOutput("s4_val_old", signal, 11);
        checkOutput("s4_level", level, 1);
        wait_strobe(n);
        checkOutput("s4_gap", n, 128);
        checkOutput("s4_val_new", signal, 22);
        checkOutput("s4_underflow", underflow, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        step(2);

        $display("[TB] reset mid-operation");
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i), 1'b0);
            step(1);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        step(60);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_level", level, 0);
        checkOutput("s5_ready", ready, 0);
        checkOutput("s5_signal", signal, 0);
        checkOutput("s5_underflow", underflow, 0);
        checkOutput("s5_wr_ready", wr_ready, 1);
        step(1);
        rst_n = 1'b1;
        wait_strobe(n);
        checkOutput("s5_gap", n, 128);
        checkOutput("s5_val", signal, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        $display("[TB] enable dropout");
        do_reset();
        applyStimulus(1'b1, 1'b1, 16'd33, 1'b0);
        step(1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        step(99);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        step(10);
        checkOutput("s6_no_strobe", ready, 0);
        checkOutput("s6_level", level, 1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        wait_strobe(n);
        checkOutput("s6_gap", n, 128);
        checkOutput("s6_val", signal, 33);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
